ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage sitting directly downstream of iDecode.
- Consumes decoded operands, the sign-extended immediate, control bits and the opcode field.
- Performs ALU and multiply operations, computes the branch target and branch decision, and registers everything into an EX/MEM output latch.
- Includes an iterative shift-add multiplier for MUL. While it runs, a valid/ready handshake stalls the upstream stage.

Parameters:
- WORD, 64, datapath width in bits.
- OPC_LEN, 11, width of the R-type opcode field instr[31:21].

Ports:
- clk  input  1  stage clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction present on inputs.
- in_ready  output  1  stage can accept an instruction this cycle.
- cur_pc  input  WORD  PC of the instruction.
- read_data1  input  WORD  operand A (Rn).
- read_data2  input  WORD  operand B (Rm / Rt).
- ext_addr  input  WORD  sign-extended immediate/offset.
- opcode  input  OPC_LEN  instr[31:21].
- alu_op  input  2  00 add, 01 pass-B (CBZ), 10 R-type via opcode.
- alu_src  input  1  1: B operand = ext_addr, 0: read_data2.
- branch, uncondbranch, mem_read, mem_write, mem_to_reg  input  1 each  decode control bits.
- out_valid  output  1  EX/MEM latch holds a valid result.
- alu_result  output  WORD  registered ALU/MUL result.
- zero  output  1  alu_result == 0.
- store_data  output  WORD  registered read_data2 (for STUR).
- branch_target  output  WORD  cur_pc + (ext_addr << 2).
- pc_src  output  1  uncondbranch | (branch & zero).
- mem_read_q, mem_write_q, mem_to_reg_q  output  1 each  control bits passed through the latch.
- illegal_op  output  1  R-type opcode not recognised.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - All outputs 0 and in_ready=1. The state machine goes to IDLE and the multiplier registers clear.
  - Reset has priority over everything, including a MUL in progress. An aborted MUL produces no out_valid.
- B operand mux: B = alu_src ? ext_addr : read_data2.
- ALU control:
  - alu_op 00: A+B.
  - alu_op 01: pass B.
  - alu_op 10, decoded from opcode:
    - ADD 10001011000: A+B.
    - SUB 11001011000: A-B.
    - AND 10001010000: A&B.
    - ORR 10101010000: A|B.
    - MUL 10011011000: low WORD bits of A*B.
    - Any other opcode: result 0, illegal_op=1.
  - alu_op 11: treated as an illegal opcode.
- Arithmetic is modulo 2^WORD; overflow and carry are discarded. branch_target shifts ext_addr left by 2, truncates to WORD, and adds modulo 2^WORD.
- State machine: IDLE, MUL_BUSY.
  - IDLE, in_valid=1, non-MUL: the result and every _q/branch output latch on that edge; out_valid=1 for exactly one cycle. Latency is 1 cycle. Back-to-back issue is allowed every cycle.
  - IDLE, in_valid=0: out_valid=0. Other outputs hold their last values.
  - IDLE, in_valid=1, MUL:
    - Capture multiplicand=A, multiplier=B, acc=0, count=0, plus all control/PC fields.
    - Go to MUL_BUSY; in_ready drops to 0 from the next cycle; out_valid=0.
  - MUL_BUSY, each cycle:
    - If multiplier[0] is set, acc += multiplicand.
    - Shift multiplicand left 1 and multiplier right 1; count++.
    - When count reaches WORD-1 (the WORD-th iteration), the final acc is written to alu_result, out_valid=1, in_ready=1, and the state returns to IDLE.
  - MUL latency: WORD+1 cycles from the accept edge to out_valid.
- in_ready=0 only while in MUL_BUSY. Inputs presented then are ignored; upstream must hold them.
- zero and pc_src are computed from the latched result and registered in the same edge as alu_result.
- pc_src is meaningful only when out_valid=1. It is forced to 0 whenever out_valid=0.
- store_data latches read_data2 regardless of alu_src.

Test Plan:
- Reset pulse, then ADD with A=20, B=10 (alu_op 10) -> 1 cycle later: out_valid=1, alu_result=30, zero=0, pc_src=0.
- SUB with A=30, B=30, followed next cycle by ORR with A=0x1C, B=0x02 -> consecutive out_valid cycles: result 0 with zero=1, then 30 with zero=0.
- CBZ: alu_op 01, branch=1, read_data2=0, cur_pc=0x40, ext_addr=3 -> pc_src=1, branch_target=0x4C. Repeat with read_data2=5 -> pc_src=0.
- LDUR: alu_op 00, alu_src=1, A=0x100, ext_addr=8, mem_read=1, mem_to_reg=1 -> alu_result=0x108, mem_read_q=1, mem_to_reg_q=1.
- MUL with A=7, B=6 -> in_ready=0 for WORD cycles, out_valid rises exactly WORD+1 cycles after accept, alu_result=42. Also MUL of 0xFFFF_FFFF_FFFF_FFFF × 2 -> alu_result=0xFFFF_FFFF_FFFF_FFFE.
- Reset asserted 10 cycles into a MUL -> next cycle: in_ready=1, out_valid=0, alu_result=0. Then an ADD 1+1 gives 2 with 1-cycle latency.
- Opcode 11111111111 with alu_op 10 -> illegal_op=1, alu_result=0, zero=1.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage downstream of instruction decode.
//
// Selects the B operand, runs the ALU (add / sub / and / orr / pass-B), runs
// MUL on an iterative shift-add multiplier, forms the branch target and
// decision, and registers everything into the EX/MEM output latch.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid / in_ready upstream handshake; in_ready is low only while a MUL
//                       is iterating, and upstream must hold its inputs then
//   cur_pc, read_data1, read_data2, ext_addr, opcode, alu_op, alu_src
//                       decoded operands and ALU controls
//   branch, uncondbranch, mem_read, mem_write, mem_to_reg
//                       decode control bits
//   out_valid           one-cycle pulse when the EX/MEM latch takes a result
//   alu_result, zero, store_data, branch_target, pc_src,
//   mem_read_q, mem_write_q, mem_to_reg_q, illegal_op
//                       EX/MEM latch contents
module ex_stage #(
    parameter int WORD    = 64,
    parameter int OPC_LEN = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD-1:0]    cur_pc,
    input  logic [WORD-1:0]    read_data1,
    input  logic [WORD-1:0]    read_data2,
    input  logic [WORD-1:0]    ext_addr,
    input  logic [OPC_LEN-1:0] opcode,
    input  logic [1:0]         alu_op,
    input  logic               alu_src,
    input  logic               branch,
    input  logic               uncondbranch,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               mem_to_reg,
    output logic               out_valid,
    output logic [WORD-1:0]    alu_result,
    output logic               zero,
    output logic [WORD-1:0]    store_data,
    output logic [WORD-1:0]    branch_target,
    output logic               pc_src,
    output logic               mem_read_q,
    output logic               mem_write_q,
    output logic               mem_to_reg_q,
    output logic               illegal_op
);

    localparam int CW = $clog2(WORD);

    localparam logic [OPC_LEN-1:0] OPC_ADD = OPC_LEN'(11'b10001011000);
    localparam logic [OPC_LEN-1:0] OPC_SUB = OPC_LEN'(11'b11001011000);
    localparam logic [OPC_LEN-1:0] OPC_AND = OPC_LEN'(11'b10001010000);
    localparam logic [OPC_LEN-1:0] OPC_ORR = OPC_LEN'(11'b10101010000);
    localparam logic [OPC_LEN-1:0] OPC_MUL = OPC_LEN'(11'b10011011000);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t state_q, state_d;

    // Multiplier working registers.
    logic [WORD-1:0] mcand_q, mcand_d;
    logic [WORD-1:0] mplier_q, mplier_d;
    logic [WORD-1:0] acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Fields of the in-flight MUL, held until the product is ready.
    logic [WORD-1:0] s_store_q, s_store_d;
    logic [WORD-1:0] s_target_q, s_target_d;
    logic            s_branch_q, s_branch_d;
    logic            s_uncond_q, s_uncond_d;
    logic            s_mr_q, s_mr_d;
    logic            s_mw_q, s_mw_d;
    logic            s_mtr_q, s_mtr_d;

    // EX/MEM output latch.
    logic            out_valid_q, out_valid_d;
    logic [WORD-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic [WORD-1:0] store_q, store_d;
    logic [WORD-1:0] target_q, target_d;
    logic            pc_src_q, pc_src_d;
    logic            mr_q, mr_d;
    logic            mw_q, mw_d;
    logic            mtr_q, mtr_d;
    logic            illegal_q, illegal_d;

    // Combinational ALU.
    logic [WORD-1:0] b_op;
    logic [WORD-1:0] alu_res;
    logic            alu_ill;
    logic            is_mul;
    logic [WORD-1:0] target_in;
    logic [WORD-1:0] acc_next;

    assign b_op      = alu_src ? ext_addr : read_data2;
    assign target_in = cur_pc + (ext_addr << 2);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case statements can leave it unassigned and infer a latch.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        is_mul  = 1'b0;
        unique case (alu_op)
            2'b00: alu_res = read_data1 + b_op;
            2'b01: alu_res = b_op;
            2'b10: begin
                if (opcode == OPC_ADD)      alu_res = read_data1 + b_op;
                else if (opcode == OPC_SUB) alu_res = read_data1 - b_op;
                else if (opcode == OPC_AND) alu_res = read_data1 & b_op;
                else if (opcode == OPC_ORR) alu_res = read_data1 | b_op;
                else if (opcode == OPC_MUL) is_mul  = 1'b1;
                else                        alu_ill = 1'b1;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // Next-state and output-latch logic.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        s_store_d   = s_store_q;
        s_target_d  = s_target_q;
        s_branch_d  = s_branch_q;
        s_uncond_d  = s_uncond_q;
        s_mr_d      = s_mr_q;
        s_mw_d      = s_mw_q;
        s_mtr_d     = s_mtr_q;
        result_d    = result_q;
        zero_d      = zero_q;
        store_d     = store_q;
        target_d    = target_q;
        mr_d        = mr_q;
        mw_d        = mw_q;
        mtr_d       = mtr_q;
        illegal_d   = illegal_q;
        // out_valid is a pulse and pc_src is only meaningful alongside it.
        out_valid_d = 1'b0;
        pc_src_d    = 1'b0;
        acc_next    = acc_q + (mplier_q[0] ? mcand_q : '0);

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
                        mcand_d    = read_data1;
                        mplier_d   = b_op;
                        acc_d      = '0;
                        cnt_d      = '0;
                        s_store_d  = read_data2;
                        s_target_d = target_in;
                        s_branch_d = branch;
                        s_uncond_d = uncondbranch;
                        s_mr_d     = mem_read;
                        s_mw_d     = mem_write;
                        s_mtr_d    = mem_to_reg;
                        state_d    = MUL_BUSY;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        store_d     = read_data2;
                        target_d    = target_in;
                        pc_src_d    = uncondbranch | (branch & (alu_res == '0));
                        mr_d        = mem_read;
                        mw_d        = mem_write;
                        mtr_d       = mem_to_reg;
                        illegal_d   = alu_ill;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Last iteration: acc_next already includes the final partial
                // product, so it goes straight into the output latch.
                if (cnt_q == CW'(WORD - 1)) begin
                    result_d    = acc_next;
                    zero_d      = (acc_next == '0);
                    store_d     = s_store_q;
                    target_d    = s_target_q;
                    pc_src_d    = s_uncond_q | (s_branch_q & (acc_next == '0));
                    mr_d        = s_mr_q;
                    mw_d        = s_mw_q;
                    mtr_d       = s_mtr_q;
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            s_store_q   <= '0;
            s_target_q  <= '0;
            s_branch_q  <= 1'b0;
            s_uncond_q  <= 1'b0;
            s_mr_q      <= 1'b0;
            s_mw_q      <= 1'b0;
            s_mtr_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            store_q     <= '0;
            target_q    <= '0;
            pc_src_q    <= 1'b0;
            mr_q        <= 1'b0;
            mw_q        <= 1'b0;
            mtr_q       <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            s_store_q   <= s_store_d;
            s_target_q  <= s_target_d;
            s_branch_q  <= s_branch_d;
            s_uncond_q  <= s_uncond_d;
            s_mr_q      <= s_mr_d;
            s_mw_q      <= s_mw_d;
            s_mtr_q     <= s_mtr_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            store_q     <= store_d;
            target_q    <= target_d;
            pc_src_q    <= pc_src_d;
            mr_q        <= mr_d;
            mw_q        <= mw_d;
            mtr_q       <= mtr_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = out_valid_q;
    assign alu_result    = result_q;
    assign zero          = zero_q;
    assign store_data    = store_q;
    assign branch_target = target_q;
    assign pc_src        = pc_src_q;
    assign mem_read_q    = mr_q;
    assign mem_write_q   = mw_q;
    assign mem_to_reg_q  = mtr_q;
    assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard testbench for ex_stage: the driver pushes the expected EX/MEM
// contents (and the cycle they must appear) from a reference model; a monitor
// pops and compares whenever out_valid is seen.
module tb_ex_stage;

    localparam int WORD = 64;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    typedef struct {
        logic [63:0] a, rd2, ext, pc;
        logic [10:0] opc;
        logic [1:0]  aop;
        logic        asrc, br, ub, mr, mw, mtr;
    } stim_t;

    typedef struct {
        logic [63:0] res, store, target;
        logic        zero, pc_src, mr, mw, mtr, ill, mul;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] cur_pc = '0, read_data1 = '0, read_data2 = '0, ext_addr = '0;
    logic [10:0] opcode = '0;
    logic [1:0]  alu_op = '0;
    logic        alu_src = 1'b0, branch = 1'b0, uncondbranch = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
    logic        out_valid, zero, pc_src, mem_read_q, mem_write_q, mem_to_reg_q, illegal_op;
    logic [63:0] alu_result, store_data, branch_target;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];

    ex_stage #(.WORD(WORD), .OPC_LEN(11)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cur_pc(cur_pc), .read_data1(read_data1), .read_data2(read_data2),
        .ext_addr(ext_addr), .opcode(opcode), .alu_op(alu_op), .alu_src(alu_src),
        .branch(branch), .uncondbranch(uncondbranch), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .out_valid(out_valid),
        .alu_result(alu_result), .zero(zero), .store_data(store_data),
        .branch_target(branch_target), .pc_src(pc_src), .mem_read_q(mem_read_q),
        .mem_write_q(mem_write_q), .mem_to_reg_q(mem_to_reg_q), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: straight from the operation table, MUL as a plain product.
    function automatic exp_t model(input stim_t s);
        exp_t        e;
        logic [63:0] b;
        b     = s.asrc ? s.ext : s.rd2;
        e.res = '0;
        e.ill = 1'b0;
        e.mul = 1'b0;
        if (s.aop == 2'b00)      e.res = s.a + b;
        else if (s.aop == 2'b01) e.res = b;
        else if (s.aop == 2'b10) begin
            if (s.opc == OPC_ADD)      e.res = s.a + b;
            else if (s.opc == OPC_SUB) e.res = s.a - b;
            else if (s.opc == OPC_AND) e.res = s.a & b;
            else if (s.opc == OPC_ORR) e.res = s.a | b;
            else if (s.opc == OPC_MUL) begin
                e.res = s.a * b;
                e.mul = 1'b1;
            end else e.ill = 1'b1;
        end else e.ill = 1'b1;
        e.zero   = (e.res == 64'd0);
        e.pc_src = s.ub | (s.br & e.zero);
        e.store  = s.rd2;
        e.target = s.pc + (s.ext << 2);
        e.mr     = s.mr;
        e.mw     = s.mw;
        e.mtr    = s.mtr;
        e.due    = 0;
        return e;
    endfunction

    function automatic stim_t blank();
        stim_t s;
        s.a = '0; s.rd2 = '0; s.ext = '0; s.pc = '0;
        s.opc = '0; s.aop = '0;
        s.asrc = 0; s.br = 0; s.ub = 0; s.mr = 0; s.mw = 0; s.mtr = 0;
        return s;
    endfunction

    function automatic stim_t rtype(input logic [10:0] opc, input logic [63:0] a, input logic [63:0] b);
        stim_t s;
        s     = blank();
        s.aop = 2'b10;
        s.opc = opc;
        s.a   = a;
        s.rd2 = b;
        return s;
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic issue(input stim_t s);
        exp_t e;
        int   waited;
        read_data1 = s.a; read_data2 = s.rd2; ext_addr = s.ext; cur_pc = s.pc;
        opcode = s.opc; alu_op = s.aop; alu_src = s.asrc; branch = s.br;
        uncondbranch = s.ub; mem_read = s.mr; mem_write = s.mw; mem_to_reg = s.mtr;
        in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("ready_timeout", {63'd0, in_ready}, 64'd1);
        end else begin
            e     = model(s);
            e.due = cyc + 1 + (e.mul ? WORD : 0);
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Monitor: compare each out_valid pulse against the scoreboard head.
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency_cycle", 64'(cyc), 64'(e.due));
                    check("alu_result", alu_result, e.res);
                    check("zero", {63'd0, zero}, {63'd0, e.zero});
                    check("pc_src", {63'd0, pc_src}, {63'd0, e.pc_src});
                    check("store_data", store_data, e.store);
                    check("branch_target", branch_target, e.target);
                    check("mem_read_q", {63'd0, mem_read_q}, {63'd0, e.mr});
                    check("mem_write_q", {63'd0, mem_write_q}, {63'd0, e.mw});
                    check("mem_to_reg_q", {63'd0, mem_to_reg_q}, {63'd0, e.mtr});
                    check("illegal_op", {63'd0, illegal_op}, {63'd0, e.ill});
                end
            end else if (pc_src) begin
                check("pc_src_without_valid", 64'd1, 64'd0);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_alu_result"}, alu_result, 64'd0);
        check({tag, "_outs_zero"},
              {57'd0, zero, pc_src, mem_read_q, mem_write_q, mem_to_reg_q, illegal_op, 1'b0}, 64'd0);
        check({tag, "_store_target"}, store_data | branch_target, 64'd0);
    endtask

    initial begin
        stim_t s;
        int    low;
        int    drain;

        // Reset pulse.
        idle(3);
        reset = 1'b0;
        check_reset_state("reset");

        // ADD 20 + 10.
        issue(rtype(OPC_ADD, 64'd20, 64'd10));
        // SUB 30-30 then ORR 0x1C|0x02, back to back.
        issue(rtype(OPC_SUB, 64'd30, 64'd30));
        issue(rtype(OPC_ORR, 64'h1C, 64'h02));
        idle(2);

        // CBZ taken and not taken.
        s = blank(); s.aop = 2'b01; s.br = 1; s.rd2 = 64'd0; s.pc = 64'h40; s.ext = 64'd3;
        issue(s);
        s.rd2 = 64'd5;
        issue(s);

        // LDUR address computation.
        s = blank(); s.aop = 2'b00; s.asrc = 1; s.a = 64'h100; s.ext = 64'd8; s.mr = 1; s.mtr = 1;
        issue(s);

        // MUL 7*6, counting the cycles in_ready stays low.
        issue(rtype(OPC_MUL, 64'd7, 64'd6));
        low = 0;
        while (!in_ready && low < 200) begin
            low++;
            @(negedge clk);
        end
        check("mul_ready_low_cycles", 64'(low), 64'(WORD));
        issue(rtype(OPC_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2));
        idle(WORD + 4);

        // Illegal opcode.
        issue(rtype(11'b11111111111, 64'd5, 64'd9));
        // alu_op 11 is illegal as well.
        s = rtype(OPC_ADD, 64'd5, 64'd9); s.aop = 2'b11;
        issue(s);
        idle(2);

        // Reset ten cycles into a MUL aborts it.
        issue(rtype(OPC_MUL, 64'd123, 64'd456));
        idle(9);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        check_reset_state("abort");
        issue(rtype(OPC_ADD, 64'd1, 64'd1));
        idle(WORD + 10);

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            logic [10:0] opcs[6];
            opcs[0] = OPC_ADD; opcs[1] = OPC_SUB; opcs[2] = OPC_AND;
            opcs[3] = OPC_ORR; opcs[4] = OPC_MUL; opcs[5] = 11'($urandom);
            s      = blank();
            s.a    = {$urandom, $urandom};
            s.rd2  = ($urandom_range(0, 3) == 0) ? s.a : {$urandom, $urandom};
            s.ext  = ($urandom_range(0, 1) == 0) ? 64'($signed(16'($urandom))) : {$urandom, $urandom};
            s.pc   = {$urandom, $urandom};
            s.aop  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) s.aop = 2'b10;
            s.opc  = opcs[$urandom_range(0, 5)];
            if (s.opc == OPC_MUL && $urandom_range(0, 2) != 0) s.opc = OPC_ADD;
            if (s.aop == 2'b01 && $urandom_range(0, 1) == 0) s.rd2 = '0;
            s.asrc = 1'($urandom);
            s.br   = 1'($urandom);
            s.ub   = ($urandom_range(0, 5) == 0);
            s.mr   = 1'($urandom);
            s.mw   = 1'($urandom);
            s.mtr  = 1'($urandom);
            issue(s);
            idle($urandom_range(0, 2));
        end

        // Drain the scoreboard.
        drain = 0;
        while (sb.size() != 0 && drain < 200) begin
            @(negedge clk);
            drain++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
